// File: rtl/tube_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tube_scan_ctrl
//
// Time-multiplexed scan controller for a common-anode 7-segment tube array.
// Each digit holds a 5-bit code {dp, hex[3:0]}. Software writes a shadow
// register set and then requests a commit. The shadow set is copied into
// the active set only at a frame boundary, so a frame never mixes old and
// new data. Every digit slot starts with a short all-off blanking window
// that suppresses ghosting. During that window seg_num is already loaded,
// so the segment lines are stable before the digit is switched on.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wr_en        shadow write strobe (one digit per cycle)
//   wr_addr      shadow digit index; indices >= N_DIG are ignored
//   wr_data      {dp, hex[3:0]}
//   commit       1-cycle request to copy shadow->active at the next frame end
//   dig_mask     per-digit enable (1 = enabled), applied live
//   seg_num      code driven to the seven-segment decoder
//   dig_sel      active-low digit selects, bit i = digit i
//   commit_pend  a commit is requested and not yet applied
//   frame_done   1-cycle pulse when a commit has been applied
//
// Optional feature macro: TUBE_LZB_EN (leading-zero blanking). When the
// macro is defined, a digit whose own code and every higher-index code are
// all zero (hex = 0 and dp = 0) stays dark. Digit 0 is never blanked.
// ---------------------------------------------------------------------------
module tube_scan_ctrl #(
  parameter int N_DIG     = 8,
  parameter int DIV_CNT   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [4:0]       wr_data,
  input  logic             commit,
  input  logic [N_DIG-1:0] dig_mask,
  output logic [4:0]       seg_num,
  output logic [N_DIG-1:0] dig_sel,
  output logic             commit_pend,
  output logic             frame_done
);

  localparam int CW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CNT - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [0:0]       state_q, state_d;
  logic [4:0]       shadow_q [N_DIG];
  logic [4:0]       active_q [N_DIG];
  logic [4:0]       seg_q, seg_d;
  logic [N_DIG-1:0] sel_q, sel_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;

  logic slot_end;
  logic frame_end;
  logic copy;
  logic wr_ok;
  logic lz_blank;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign copy      = frame_end && pend_q;
  assign wr_ok     = wr_en && (int'(wr_addr) < N_DIG);

`ifdef TUBE_LZB_EN
  // A digit is a leading zero when it and every higher digit hold code 0.
  // Only the active set matters; during SHOW it cannot change.
  logic upper_nonzero;

  always_comb begin
    upper_nonzero = 1'b0;
    for (int j = 0; j < N_DIG; j++) begin
      if ((j >= int'(idx_d)) && (active_q[j] != 5'd0)) begin
        upper_nonzero = 1'b1;
      end
    end
    lz_blank = (idx_d != '0) && !upper_nonzero;
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Next-state logic. The prescaler and digit index advance together.
  // The display outputs are computed for the state being entered, so they
  // register on the same edge as the FSM.
  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + CW'(1);

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == CNT_SHOW) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end)          state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    // The code for the next slot loads on its first blanking cycle. At a
    // frame end with a copy pending, it comes straight from the shadow set,
    // so digit 0 of the new frame already shows the new data.
    seg_d = seg_q;
    if (slot_end) begin
      seg_d = copy ? shadow_q[idx_d] : active_q[idx_d];
    end

    // A masked digit still uses its slot, with every digit off.
    sel_d = '1;
    if ((state_d == ST_SHOW) && !lz_blank) begin
      sel_d[idx_d] = ~dig_mask[idx_d];
    end

    // A commit that arrives on the copy edge starts a fresh request.
    pend_d = copy ? commit : (pend_q | commit);
    done_d = copy;
  end

  // The copy reads the pre-write shadow value. A write on the same edge
  // lands in the shadow set only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= ST_BLANK;
      seg_q   <= '0;
      sel_q   <= '1;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_DIG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      if (copy) begin
        active_q <= shadow_q;
      end
      if (wr_ok) begin
        shadow_q[wr_addr[IW-1:0]] <= wr_data;
      end
    end
  end

  assign seg_num     = seg_q;
  assign dig_sel     = sel_q;
  assign commit_pend = pend_q;
  assign frame_done  = done_q;

endmodule
